vc_input_buffer: RTL and testbench



---
 rtl/noc_params.sv | 48 ++++
 rtl/circular_buffer.sv | 52 +++++
 rtl/vc_input_buffer.sv | 112 +++++++++++
 tb/tb_vc_input_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared NoC types: flit format, port and per-VC state encodings, XY route helper.
// No logic latency; pure type/function definitions.
// No flow control here; consumers define their own backpressure.
package noc_params;

   localparam int DEST_ADDR_SIZE_X = 4;
   localparam int DEST_ADDR_SIZE_Y = 4;
   localparam int VC_NUM           = 2;
   localparam int VC_SIZE          = $clog2(VC_NUM);
   localparam int BUFFER_DEPTH     = 4;
   localparam int PORT_NUM         = 5;
   localparam int FLIT_DATA_SIZE   = 16;

   typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
   typedef enum logic [1:0] {IDLE, WAIT_VA, ACTIVE} vc_state_t;

   typedef struct packed {
      flit_label_t                 flit_label;
      logic [VC_SIZE-1:0]          vc_id;
      logic [DEST_ADDR_SIZE_X-1:0] x_dest;
      logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
      logic [FLIT_DATA_SIZE-1:0]   data;
   } flit_t;

   function automatic logic is_head(input flit_label_t l);
      return (l == HEAD) || (l == HEADTAIL);
   endfunction

   function automatic logic is_tail(input flit_label_t l);
      return (l == TAIL) || (l == HEADTAIL);
   endfunction

   // X first, then Y; unsigned coordinates.
   function automatic port_t xy_route(input logic [DEST_ADDR_SIZE_X-1:0] x_dest,
                                      input logic [DEST_ADDR_SIZE_X-1:0] x_cur,
                                      input logic [DEST_ADDR_SIZE_Y-1:0] y_dest,
                                      input logic [DEST_ADDR_SIZE_Y-1:0] y_cur);
      port_t p;
      if (x_dest > x_cur)      p = EAST;
      else if (x_dest < x_cur) p = WEST;
      else if (y_dest > y_cur) p = SOUTH;
      else if (y_dest < y_cur) p = NORTH;
      else                     p = LOCAL;
      return p;
   endfunction

endpackage

// File: rtl/circular_buffer.sv
// Single-VC circular FIFO with occupancy counter; head is a combinational read.
// Latency: write at edge t is visible on rd_dat after t.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module circular_buffer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_dat,
   output logic [WIDTH-1:0] rd_dat,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_dat  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_dat;
   end

endmodule

// File: rtl/vc_input_buffer.sv
// Router input unit: per-VC FIFO, packet FSM, XY route latch, credit return (error via VC_INPUT_BUFFER_CHECK_EN).
// Latency: HEAD written at t requests VA after t+1; credit pulses the cycle after each accepted pop.
// Backpressure: upstream is credit-limited; writes to a full VC without a same-cycle pop are dropped.
module vc_input_buffer
   import noc_params::*;
#(
   parameter int                          VC_NUM       = 2,
   parameter int                          BUFFER_DEPTH = 4,
   parameter logic [DEST_ADDR_SIZE_X-1:0] X_CURRENT    = '0,
   parameter logic [DEST_ADDR_SIZE_Y-1:0] Y_CURRENT    = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  flit_t                data_i,
   input  logic                 valid_i,
   input  logic [VC_NUM-1:0]    pop_i,
   input  logic [VC_NUM-1:0]    va_grant_i,
   output flit_t [VC_NUM-1:0]   flit_o,
   output logic [VC_NUM-1:0]    is_valid_o,
   output logic [VC_NUM-1:0]    va_request_o,
   output port_t [VC_NUM-1:0]   out_port_o,
   output logic [VC_NUM-1:0]    credit_o,
   output logic                 error_o
);

   vc_state_t         state_q [VC_NUM];
   vc_state_t         state_d [VC_NUM];
   logic [VC_NUM-1:0] push;
   logic [VC_NUM-1:0] pop_acc;
   logic [VC_NUM-1:0] empty;
`ifdef VC_INPUT_BUFFER_CHECK_EN
   logic [VC_NUM-1:0] full;
`endif

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      assign push[v]         = valid_i && (data_i.vc_id == VC_SIZE'(v));
      assign pop_acc[v]      = pop_i[v] && (state_q[v] == ACTIVE) && !empty[v];
      assign is_valid_o[v]   = (state_q[v] == ACTIVE) && !empty[v];
      assign va_request_o[v] = (state_q[v] == WAIT_VA);

      circular_buffer #(
         .DEPTH (BUFFER_DEPTH),
         .WIDTH ($bits(flit_t))
      ) u_fifo (
         .clk    (clk),
         .rst_n  (rst_n),
         .push   (push[v]),
         .pop    (pop_acc[v]),
         .wr_dat (data_i),
         .rd_dat (flit_o[v]),
         .empty  (empty[v]),
`ifdef VC_INPUT_BUFFER_CHECK_EN
         .full   (full[v])
`else
         .full   ()
`endif
      );
   end

   // A non-head flit at the head of an IDLE VC stalls it until reset.
   always_comb begin
      for (int i = 0; i < VC_NUM; i++) begin
         state_d[i] = state_q[i];
         unique case (state_q[i])
            IDLE:    if (!empty[i] && is_head(flit_o[i].flit_label)) state_d[i] = WAIT_VA;
            WAIT_VA: if (va_grant_i[i]) state_d[i] = ACTIVE;
            ACTIVE:  if (pop_acc[i] && is_tail(flit_o[i].flit_label)) state_d[i] = IDLE;
            default: state_d[i] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < VC_NUM; i++) begin
            state_q[i]    <= IDLE;
            out_port_o[i] <= LOCAL;
         end
         credit_o <= '0;
      end else begin
         for (int i = 0; i < VC_NUM; i++) begin
            state_q[i] <= state_d[i];
            if (state_q[i] == IDLE && state_d[i] == WAIT_VA)
               out_port_o[i] <= xy_route(flit_o[i].x_dest, X_CURRENT,
                                         flit_o[i].y_dest, Y_CURRENT);
         end
         credit_o <= pop_acc;
      end
   end

`ifdef VC_INPUT_BUFFER_CHECK_EN
   logic [VC_NUM-1:0] err_evt;
   logic              error_q;

   always_comb begin
      for (int i = 0; i < VC_NUM; i++) begin
         err_evt[i] = (push[i] && full[i] && !pop_acc[i]) ||
                      ((state_q[i] == IDLE) && !empty[i] && !is_head(flit_o[i].flit_label));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) error_q <= 1'b0;
      else        error_q <= error_q | (|err_evt);
   end

   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed scoreboard bench for vc_input_buffer (2 VCs, depth 4, router at (0,0)).
module tb_vc_input_buffer;
   import noc_params::*;

   logic          clk = 1'b0;
   logic          rst_n;
   flit_t         data_i;
   logic          valid_i;
   logic [1:0]    pop_i;
   logic [1:0]    va_grant_i;
   flit_t [1:0]   flit_o;
   logic [1:0]    is_valid_o;
   logic [1:0]    va_request_o;
   port_t [1:0]   out_port_o;
   logic [1:0]    credit_o;
   logic          error_o;

   int total = 0;
   int bad   = 0;
   int credits;
   flit_t q0[$];
   flit_t q1[$];

`ifdef VC_INPUT_BUFFER_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   always #5 clk = ~clk;

   vc_input_buffer #(
      .VC_NUM       (2),
      .BUFFER_DEPTH (4),
      .X_CURRENT    (4'd0),
      .Y_CURRENT    (4'd0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_i       (data_i),
      .valid_i      (valid_i),
      .pop_i        (pop_i),
      .va_grant_i   (va_grant_i),
      .flit_o       (flit_o),
      .is_valid_o   (is_valid_o),
      .va_request_o (va_request_o),
      .out_port_o   (out_port_o),
      .credit_o     (credit_o),
      .error_o      (error_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic flit_t mk(input flit_label_t l, input int vc, input int x, input int y, input int d);
      flit_t f;
      f.flit_label = l;
      f.vc_id      = 1'(vc);
      f.x_dest     = 4'(x);
      f.y_dest     = 4'(y);
      f.data       = 16'(d);
      return f;
   endfunction

   // One clock: optional write (acc = expected to be stored), pops, grants.
   // pacc marks pops the bench expects the DUT to accept.
   task automatic tick(input logic wr, input flit_t f, input logic acc,
                       input logic [1:0] pop, input logic [1:0] pacc, input logic [1:0] gnt);
      flit_t e;
      if (pacc[0]) begin
         e = q0.pop_front();
         chk("head_vc0", 32'(flit_o[0]), 32'(e));
      end
      if (pacc[1]) begin
         e = q1.pop_front();
         chk("head_vc1", 32'(flit_o[1]), 32'(e));
      end
      if (wr && acc) begin
         if (f.vc_id == 1'b0) q0.push_back(f);
         else                 q1.push_back(f);
      end
      valid_i    = wr;
      data_i     = f;
      pop_i      = pop;
      va_grant_i = gnt;
      @(posedge clk); #1;
      valid_i    = 1'b0;
      pop_i      = 2'b00;
      va_grant_i = 2'b00;
      chk("credit", 32'(credit_o), 32'(pacc));
      credits += int'(credit_o[0]) + int'(credit_o[1]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 2'b00, 2'b00, 2'b00);
   endtask

   task automatic send(input flit_t f, input logic acc);
      tick(1'b1, f, acc, 2'b00, 2'b00, 2'b00);
   endtask

   initial begin
      rst_n      = 1'b0;
      valid_i    = 1'b0;
      data_i     = '0;
      pop_i      = 2'b00;
      va_grant_i = 2'b00;
      credits    = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_is_valid", 32'(is_valid_o), 32'h0);
      chk("rst_va_req", 32'(va_request_o), 32'h0);
      chk("rst_credit", 32'(credit_o), 32'h0);
      chk("rst_error", 32'(error_o), 32'h0);
      chk("rst_port0", 32'(out_port_o[0]), 32'(LOCAL));
      chk("rst_port1", 32'(out_port_o[1]), 32'(LOCAL));
      rst_n = 1'b1;

      // HEADTAIL to VC0, dest (3,0)
      send(mk(HEADTAIL, 0, 3, 0, 16'h1111), 1'b1);
      chk("t1_no_req_yet", 32'(va_request_o), 32'h0);
      idle(1);
      chk("t1_req_c1", 32'(va_request_o), 32'h1);
      chk("t1_port_east", 32'(out_port_o[0]), 32'(EAST));
      tick(1'b0, '0, 1'b0, 2'b01, 2'b00, 2'b00);   // pop ignored in WAIT_VA
      chk("t1_req_c2", 32'(va_request_o), 32'h1);
      chk("t1_not_valid", 32'(is_valid_o), 32'h0);
      tick(1'b0, '0, 1'b0, 2'b00, 2'b00, 2'b01);
      chk("t1_req_drop", 32'(va_request_o), 32'h0);
      chk("t1_valid", 32'(is_valid_o), 32'h1);
      tick(1'b0, '0, 1'b0, 2'b01, 2'b01, 2'b00);
      chk("t1_idle_valid", 32'(is_valid_o), 32'h0);
      chk("t1_idle_req", 32'(va_request_o), 32'h0);
      idle(1);

      // HEAD, BODY, BODY, TAIL to VC1, dest (0,2)
      send(mk(HEAD, 1, 0, 2, 16'h2001), 1'b1);
      send(mk(BODY, 1, 0, 2, 16'h2002), 1'b1);
      send(mk(BODY, 1, 0, 2, 16'h2003), 1'b1);
      send(mk(TAIL, 1, 0, 2, 16'h2004), 1'b1);
      chk("t2_req", 32'(va_request_o), 32'h2);
      chk("t2_port_south", 32'(out_port_o[1]), 32'(SOUTH));
      tick(1'b0, '0, 1'b0, 2'b00, 2'b00, 2'b10);
      credits = 0;
      for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0, 2'b10, 2'b10, 2'b00);
      chk("t2_credit_count", 32'(credits), 32'd4);
      chk("t2_idle_valid", 32'(is_valid_o), 32'h0);
      chk("t2_idle_req", 32'(va_request_o), 32'h0);
      chk("t2_no_error", 32'(error_o), 32'h0);

      // Overflow VC0, then same-cycle write+pop on a full FIFO
      send(mk(HEAD, 0, 0, 3, 16'h3001), 1'b1);
      send(mk(BODY, 0, 0, 3, 16'h3002), 1'b1);
      send(mk(BODY, 0, 0, 3, 16'h3003), 1'b1);
      send(mk(TAIL, 0, 0, 3, 16'h3004), 1'b1);
      send(mk(TAIL, 0, 7, 7, 16'h3005), 1'b0);     // dropped
      chk("t3_error", 32'(error_o), 32'(EXP_ERR));
      chk("t3_req", 32'(va_request_o), 32'h1);
      chk("t3_port_south", 32'(out_port_o[0]), 32'(SOUTH));
      tick(1'b0, '0, 1'b0, 2'b00, 2'b00, 2'b01);
      tick(1'b1, mk(HEADTAIL, 0, 2, 0, 16'h4001), 1'b1, 2'b01, 2'b01, 2'b00);
      send(mk(HEADTAIL, 0, 0, 0, 16'h4002), 1'b0); // still full: dropped
      for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 2'b01, 2'b01, 2'b00);
      idle(1);
      chk("t4_req_w", 32'(va_request_o), 32'h1);
      chk("t4_port_east", 32'(out_port_o[0]), 32'(EAST));
      tick(1'b0, '0, 1'b0, 2'b00, 2'b00, 2'b01);
      tick(1'b0, '0, 1'b0, 2'b01, 2'b01, 2'b00);
      idle(2);
      chk("t4_empty_req", 32'(va_request_o), 32'h0);
      chk("t4_empty_valid", 32'(is_valid_o), 32'h0);
      chk("t4_error_sticky", 32'(error_o), 32'(EXP_ERR));

      // Interleaved packets, VC1 granted first
      send(mk(HEAD, 0, 4, 0, 16'h5001), 1'b1);
      send(mk(HEAD, 1, 0, 5, 16'h6001), 1'b1);
      idle(1);
      chk("t5_req_both", 32'(va_request_o), 32'h3);
      chk("t5_port0", 32'(out_port_o[0]), 32'(EAST));
      chk("t5_port1", 32'(out_port_o[1]), 32'(SOUTH));
      tick(1'b0, '0, 1'b0, 2'b00, 2'b00, 2'b10);
      chk("t5_valid_vc1", 32'(is_valid_o), 32'h2);
      tick(1'b1, mk(TAIL, 0, 4, 0, 16'h5002), 1'b1, 2'b10, 2'b10, 2'b00);
      tick(1'b1, mk(TAIL, 1, 0, 5, 16'h6002), 1'b1, 2'b10, 2'b00, 2'b00);
      chk("t5_valid_mid", 32'(is_valid_o), 32'h2);
      chk("t5_req_mid", 32'(va_request_o), 32'h1);
      tick(1'b0, '0, 1'b0, 2'b10, 2'b10, 2'b00);
      tick(1'b0, '0, 1'b0, 2'b00, 2'b00, 2'b01);
      tick(1'b0, '0, 1'b0, 2'b01, 2'b01, 2'b00);
      tick(1'b0, '0, 1'b0, 2'b01, 2'b01, 2'b00);
      chk("t5_done_valid", 32'(is_valid_o), 32'h0);
      chk("t5_done_req", 32'(va_request_o), 32'h0);
      chk("t5_port1_kept", 32'(out_port_o[1]), 32'(SOUTH));

      // Stalled non-head on VC1, then reset mid-packet on VC0
      send(mk(BODY, 1, 0, 0, 16'h7001), 1'b1);
      idle(1);
      chk("t6_stall_req", 32'(va_request_o), 32'h0);
      chk("t6_stall_error", 32'(error_o), 32'(EXP_ERR));
      send(mk(HEAD, 0, 1, 1, 16'h8001), 1'b1);
      idle(1);
      tick(1'b0, '0, 1'b0, 2'b00, 2'b00, 2'b01);
      tick(1'b1, mk(BODY, 0, 1, 1, 16'h8002), 1'b1, 2'b01, 2'b01, 2'b00);
      chk("t6_pre_valid", 32'(is_valid_o), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(is_valid_o), 32'h0);
      chk("t6_rst_req", 32'(va_request_o), 32'h0);
      chk("t6_rst_credit", 32'(credit_o), 32'h0);
      chk("t6_rst_error", 32'(error_o), 32'h0);
      chk("t6_rst_port0", 32'(out_port_o[0]), 32'(LOCAL));
      q0.delete();
      q1.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);
      chk("t6_post_valid", 32'(is_valid_o), 32'h0);
      chk("t6_post_error", 32'(error_o), 32'h0);
      send(mk(HEADTAIL, 1, 0, 1, 16'h9001), 1'b1);
      idle(1);
      chk("t6_new_req", 32'(va_request_o), 32'h2);
      chk("t6_new_port", 32'(out_port_o[1]), 32'(SOUTH));
      tick(1'b0, '0, 1'b0, 2'b00, 2'b00, 2'b10);
      tick(1'b0, '0, 1'b0, 2'b10, 2'b10, 2'b00);
      chk("t6_new_idle", 32'(is_valid_o | va_request_o), 32'h0);
      idle(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
